// File: rtl/waveform_an_pkg.sv
// Shared types and helpers for the waveform analyzer.
// Contents: FSM state enum, default parameter values, hysteresis threshold helpers.
package waveform_an_pkg;

    localparam int unsigned WA_DW      = 10;
    localparam int unsigned WA_PW      = 16;
    localparam int unsigned WA_MID_LVL = 512;
    localparam int unsigned WA_HYST    = 16;
    localparam int unsigned WA_MAX_PER = 65535;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        WAIT_HI = 2'd1,
        MEAS_LO = 2'd2,
        MEAS_HI = 2'd3
    } wa_state_e;

    // Lower threshold: a sample at or below this arms the next rising crossing.
    function automatic int unsigned lo_th(input int unsigned mid, input int unsigned hyst);
        return mid - hyst;
    endfunction

    // Upper threshold: an armed sample at or above this is a rising crossing.
    function automatic int unsigned hi_th(input int unsigned mid, input int unsigned hyst);
        return mid + hyst;
    endfunction

endpackage

// File: rtl/wave_minmax_tracker.sv
// Running min/max tracker for one waveform period.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_seed       restart both trackers at i_data (crossing sample)
//   i_update     fold i_data into the running min/max
//   i_data       sample value
//   o_run_min    running minimum (all-ones after reset)
//   o_run_max    running maximum (zero after reset)
module wave_minmax_tracker #(
    parameter int unsigned DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_seed,
    input  logic          i_update,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_run_min,
    output logic [DW-1:0] o_run_max
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_run_min <= '1;
            o_run_max <= '0;
        end else if (i_seed) begin
            o_run_min <= i_data;
            o_run_max <= i_data;
        end else if (i_update) begin
            if (i_data < o_run_min) o_run_min <= i_data;
            if (i_data > o_run_max) o_run_max <= i_data;
        end
    end

endmodule

// File: rtl/waveform_analyzer.sv
// Waveform period analyzer: measures period, min, max and peak-to-peak of a
// sample stream using rising crossings of a hysteresis band around MID_LVL.
// Optional feature macro: WAVEAN_PERIOD_AVG_EN (meas_period = mean of last 4 periods).
// Ports:
//   adc_clk, adc_rst_n   sample clock, asynchronous active-low reset
//   smp_valid, smp_data  qualified sample stream
//   meas_valid           one-cycle pulse, new measurement on meas_*
//   meas_period          samples per period (or running mean when averaging)
//   meas_min/max/pp      extremes of the period and their difference
//   meas_timeout         one-cycle pulse, MAX_PER samples without a crossing
//   locked               set by a published period, cleared by timeout
module waveform_analyzer
    import waveform_an_pkg::*;
#(
    parameter int unsigned DW      = WA_DW,
    parameter int unsigned PW      = WA_PW,
    parameter int unsigned MID_LVL = WA_MID_LVL,
    parameter int unsigned HYST    = WA_HYST,
    parameter int unsigned MAX_PER = WA_MAX_PER
) (
    input  logic          adc_clk,
    input  logic          adc_rst_n,
    input  logic          smp_valid,
    input  logic [DW-1:0] smp_data,
    output logic          meas_valid,
    output logic [PW-1:0] meas_period,
    output logic [DW-1:0] meas_min,
    output logic [DW-1:0] meas_max,
    output logic [DW-1:0] meas_pp,
    output logic          meas_timeout,
    output logic          locked
);

    localparam logic [DW-1:0] LO_TH   = DW'(lo_th(MID_LVL, HYST));
    localparam logic [DW-1:0] HI_TH   = DW'(hi_th(MID_LVL, HYST));
    localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PER);

    wa_state_e     r_state;
    wa_state_e     w_state_nxt;
    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_cnt_inc;
    logic          w_is_lo;
    logic          w_is_hi;
    logic          w_seed;
    logic          w_publish;
    logic          w_timeout;
    logic          w_track;
    logic [DW-1:0] w_run_min;
    logic [DW-1:0] w_run_max;
    logic [PW-1:0] w_period;

    assign w_is_lo   = (smp_data <= LO_TH);
    assign w_is_hi   = (smp_data >= HI_TH);
    assign w_cnt_inc = r_cnt + PW'(1);

    // State register
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) r_state <= ARM;
        else            r_state <= w_state_nxt;
    end

    // Next state and per-sample strobes; a crossing takes priority over timeout
    always_comb begin
        w_state_nxt = r_state;
        w_seed      = 1'b0;
        w_publish   = 1'b0;
        w_timeout   = 1'b0;
        w_track     = 1'b0;
        if (smp_valid) begin
            unique case (r_state)
                ARM: begin
                    if (w_is_lo) w_state_nxt = WAIT_HI;
                end
                WAIT_HI: begin
                    if (w_is_hi) begin
                        w_seed      = 1'b1;
                        w_state_nxt = MEAS_LO;
                    end else if (w_cnt_inc == MAX_CNT) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ARM;
                    end
                end
                MEAS_LO: begin
                    if (w_cnt_inc == MAX_CNT) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ARM;
                    end else begin
                        w_track = 1'b1;
                        if (w_is_lo) w_state_nxt = MEAS_HI;
                    end
                end
                MEAS_HI: begin
                    if (w_is_hi) begin
                        w_publish   = 1'b1;
                        w_seed      = 1'b1;
                        w_state_nxt = MEAS_LO;
                    end else if (w_cnt_inc == MAX_CNT) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ARM;
                    end else begin
                        w_track = 1'b1;
                    end
                end
                default: w_state_nxt = ARM;
            endcase
        end
    end

    // Sample counter; the arming sample counts so a DC input times out every MAX_PER samples
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_cnt <= '0;
        end else if (smp_valid) begin
            if (w_timeout)             r_cnt <= '0;
            else if (w_seed)           r_cnt <= PW'(1);
            else if (r_state == ARM) begin
                if (w_is_lo)           r_cnt <= PW'(1);
            end else                   r_cnt <= w_cnt_inc;
        end
    end

    wave_minmax_tracker #(
        .DW (DW)
    ) u_tracker (
        .clk       (adc_clk),
        .rst_n     (adc_rst_n),
        .i_seed    (w_seed),
        .i_update  (w_track),
        .i_data    (smp_data),
        .o_run_min (w_run_min),
        .o_run_max (w_run_max)
    );

`ifdef WAVEAN_PERIOD_AVG_EN
    localparam int unsigned SW = PW + 2;
    localparam int unsigned MW = SW + 7;

    logic [PW-1:0] r_hist [3];
    logic [1:0]    r_hcnt;
    logic [SW-1:0] w_sum;
    logic [MW-1:0] w_prod;

    // Mean of the new period and up to three previous ones; /3 approximated by *85>>8
    always_comb begin
        w_sum  = SW'(r_cnt) + SW'(r_hist[0]) + SW'(r_hist[1]) + SW'(r_hist[2]);
        w_prod = MW'(w_sum) * MW'(85);
        case (r_hcnt)
            2'd0:    w_period = PW'(w_sum);
            2'd1:    w_period = PW'(w_sum >> 1);
            2'd2:    w_period = PW'(w_prod >> 8);
            default: w_period = PW'(w_sum >> 2);
        endcase
    end

    // Period history; empty entries stay zero so the sum needs no masking
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_hist <= '{default: '0};
            r_hcnt <= '0;
        end else if (w_timeout) begin
            r_hist <= '{default: '0};
            r_hcnt <= '0;
        end else if (w_publish) begin
            r_hist[2] <= r_hist[1];
            r_hist[1] <= r_hist[0];
            r_hist[0] <= r_cnt;
            if (r_hcnt != 2'd3) r_hcnt <= r_hcnt + 2'd1;
        end
    end
`else
    assign w_period = r_cnt;
`endif

    // Registered outputs; meas_* hold until the next publish
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            meas_valid   <= 1'b0;
            meas_period  <= '0;
            meas_min     <= '0;
            meas_max     <= '0;
            meas_pp      <= '0;
            meas_timeout <= 1'b0;
            locked       <= 1'b0;
        end else begin
            meas_valid   <= w_publish;
            meas_timeout <= w_timeout;
            if (w_publish) begin
                meas_period <= w_period;
                meas_min    <= w_run_min;
                meas_max    <= w_run_max;
                meas_pp     <= w_run_max - w_run_min;
                locked      <= 1'b1;
            end else if (w_timeout) begin
                locked      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_waveform_analyzer.sv
// Self-checking bench for waveform_analyzer: table-driven periodic waveforms
// plus directed sequences for reset, chatter, DC timeout and period averaging.
module tb_waveform_analyzer;

    localparam int unsigned DW   = 10;
    localparam int unsigned PW   = 16;
    localparam int unsigned MAXP = 3000;

    logic          adc_clk   = 1'b0;
    logic          adc_rst_n = 1'b0;
    logic          smp_valid = 1'b0;
    logic [DW-1:0] smp_data  = '0;
    logic          meas_valid;
    logic [PW-1:0] meas_period;
    logic [DW-1:0] meas_min;
    logic [DW-1:0] meas_max;
    logic [DW-1:0] meas_pp;
    logic          meas_timeout;
    logic          locked;

    int n_checks = 0;
    int n_errors = 0;

    always #5 adc_clk = ~adc_clk;

    waveform_analyzer #(
        .DW      (DW),
        .PW      (PW),
        .MID_LVL (512),
        .HYST    (16),
        .MAX_PER (MAXP)
    ) dut (
        .adc_clk      (adc_clk),
        .adc_rst_n    (adc_rst_n),
        .smp_valid    (smp_valid),
        .smp_data     (smp_data),
        .meas_valid   (meas_valid),
        .meas_period  (meas_period),
        .meas_min     (meas_min),
        .meas_max     (meas_max),
        .meas_pp      (meas_pp),
        .meas_timeout (meas_timeout),
        .locked       (locked)
    );

    typedef struct {
        string name;
        int    kind;     // 0 triangle, 1 sawtooth, 2 square 400/700
        int    per;      // square period
        bit    toggle;   // insert an invalid cycle after every valid sample
        int    nsmp;
        int    e_per;
        int    e_min;
        int    e_max;
        int    e_cnt;
        int    e_space;
    } vec_t;

    vec_t vecs [4];

    int n_meas;
    int last_cyc;
    int cyc;
    int first_t;
    int to_cnt;
    int to_idx [2];
    int av_per [4];
    int av_min [4];
    int av_max [4];
    int n_av;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle, then settle just past the rising edge
    task automatic step(input logic v, input logic [DW-1:0] d);
        smp_valid = v;
        smp_data  = d;
        @(posedge adc_clk);
        #1;
    endtask

    task automatic do_reset();
        adc_rst_n = 1'b0;
        smp_valid = 1'b0;
        smp_data  = '0;
        repeat (3) @(posedge adc_clk);
        #1;
        adc_rst_n = 1'b1;
        @(posedge adc_clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"},   int'(meas_valid),   0);
        check({tag, " period"},  int'(meas_period),  0);
        check({tag, " max"},     int'(meas_max),     0);
        check({tag, " timeout"}, int'(meas_timeout), 0);
        check({tag, " locked"},  int'(locked),       0);
    endtask

    function automatic logic [DW-1:0] wave(input int kind, input int t, input int p);
        int c;
        case (kind)
            0: begin
                c = t % 2048;
                return (c < 1024) ? DW'(c) : DW'(2047 - c);
            end
            1:       return DW'(t % 1024);
            default: return ((t % p) < (p / 2)) ? DW'(400) : DW'(700);
        endcase
    endfunction

    task automatic observe(input vec_t v);
        if (meas_valid) begin
            check({v.name, " period"}, int'(meas_period), v.e_per);
            check({v.name, " min"},    int'(meas_min),    v.e_min);
            check({v.name, " max"},    int'(meas_max),    v.e_max);
            check({v.name, " pp"},     int'(meas_pp),     v.e_max - v.e_min);
            if (n_meas > 0) check({v.name, " spacing"}, cyc - last_cyc, v.e_space);
            last_cyc = cyc;
            n_meas++;
        end
        if (meas_timeout) check({v.name, " spurious timeout"}, 1, 0);
    endtask

    // Constant segment of the averaging sequence, collecting publishes
    task automatic seg(input logic [DW-1:0] val, input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, val);
            if (meas_valid) begin
                if (n_av < 4) begin
                    av_per[n_av] = int'(meas_period);
                    av_min[n_av] = int'(meas_min);
                    av_max[n_av] = int'(meas_max);
                end
                n_av++;
            end
        end
    endtask

    initial begin
        int lo_len [4];
        int e_avg  [4];
        logic [DW-1:0] d;

        vecs[0] = '{"triangle",    0, 0,   1'b0, 6744, 2048, 0,   1023, 3, 2048};
        vecs[1] = '{"sawtooth",    1, 0,   1'b0, 3672, 1024, 0,   1023, 3, 1024};
        vecs[2] = '{"square",      2, 100, 1'b0, 560,  100,  400, 700,  5, 100};
        vecs[3] = '{"tri_toggled", 0, 0,   1'b1, 6744, 2048, 0,   1023, 3, 4096};

        // Reset state
        do_reset();
        check_zero("reset");

        // Periodic waveforms
        for (int i = 0; i < 4; i++) begin
            do_reset();
            n_meas   = 0;
            last_cyc = 0;
            cyc      = 0;
            for (int t = 0; t < vecs[i].nsmp; t++) begin
                d = wave(vecs[i].kind, t, vecs[i].per);
                step(1'b1, d);
                cyc++;
                observe(vecs[i]);
                if (vecs[i].toggle) begin
                    step(1'b0, ~d);
                    cyc++;
                    observe(vecs[i]);
                end
            end
            check({vecs[i].name, " count"},  n_meas,      vecs[i].e_cnt);
            check({vecs[i].name, " locked"}, int'(locked), 1);
        end

        // Reset while in MEAS_HI, then re-acquire from ARM
        do_reset();
        for (int t = 0; t < 3800; t++) step(1'b1, wave(0, t, 0));
        check("pre-reset locked", int'(locked), 1);
        #2;
        adc_rst_n = 1'b0;
        #1;
        check_zero("mid reset");
        @(posedge adc_clk);
        #1;
        adc_rst_n = 1'b1;
        n_meas  = 0;
        first_t = -1;
        for (int t = 4200; t <= 6700; t++) begin
            step(1'b1, wave(0, t, 0));
            if (meas_valid) begin
                if (n_meas == 0) begin
                    first_t = t;
                    check("reacquire period", int'(meas_period), 2048);
                end
                n_meas++;
            end
        end
        check("reacquire count", n_meas, 1);
        check("reacquire sample", first_t, 6672);

        // Chatter inside the hysteresis band from MEAS_LO with count 29
        to_cnt = 0;
        to_idx[0] = -1;
        n_meas = 0;
        for (int k = 1; k <= 3100; k++) begin
            step(1'b1, (k % 2 == 1) ? DW'(500) : DW'(520));
            if (meas_valid) n_meas++;
            if (meas_timeout) begin
                if (to_cnt == 0) to_idx[0] = k;
                to_cnt++;
            end
        end
        check("chatter meas_valid", n_meas, 0);
        check("chatter timeout count", to_cnt, 1);
        check("chatter timeout sample", to_idx[0], MAXP - 29);
        check("chatter locked", int'(locked), 0);
        check("chatter held period", int'(meas_period), 2048);
        check("chatter held pp", int'(meas_pp), 1023);

        // DC input from ARM: timeouts repeat every MAX_PER samples
        to_cnt = 0;
        to_idx[0] = -1;
        to_idx[1] = -1;
        for (int k = 1; k <= 2 * MAXP + 100; k++) begin
            step(1'b1, DW'(0));
            if (meas_timeout) begin
                if (to_cnt < 2) to_idx[to_cnt] = k;
                to_cnt++;
            end
        end
        check("dc timeout count", to_cnt, 2);
        check("dc first timeout", to_idx[0], MAXP);
        check("dc second timeout", to_idx[1], 2 * MAXP);

        // Square 0/1023 with periods 1000,1000,2000,2000
        lo_len = '{500, 500, 1500, 1500};
`ifdef WAVEAN_PERIOD_AVG_EN
        e_avg = '{1000, 1000, 1328, 1500};
`else
        e_avg = '{1000, 1000, 2000, 2000};
`endif
        do_reset();
        n_av = 0;
        seg(DW'(0), 10);
        for (int i = 0; i < 4; i++) begin
            seg(DW'(1023), 500);
            seg(DW'(0), lo_len[i]);
        end
        seg(DW'(1023), 1);
        check("avg count", n_av, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("avg period %0d", i), av_per[i], e_avg[i]);
            check($sformatf("avg min %0d", i),    av_min[i], 0);
            check($sformatf("avg max %0d", i),    av_max[i], 1023);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
